// File: rtl/sprite_line_scheduler_if.sv
// Bus between the sprite line scheduler and its environment: line start
// request, SAT read port, descriptor handshake to the renderer and status.
interface sprite_line_scheduler_if;
    logic       LSTART;
    logic [8:0] SPVP;
    logic       SPRB;
    logic [11:0] SATA;
    logic [7:0] SATD;
    logic       DV;
    logic       DRDY;
    logic [8:0] DPX;
    logic [8:0] DCODE;
    logic [3:0] DCOL;
    logic       DFX;
    logic       DFY;
    logic [3:0] DLY;
    logic       BUSY;
    logic [5:0] HITCNT;
    logic       OVF;

    // Scheduler side.
    modport master (
        input  LSTART, SPVP, SPRB, SATD, DRDY,
        output SATA, DV, DPX, DCODE, DCOL, DFX, DFY, DLY, BUSY, HITCNT, OVF
    );

    // Line sequencer / SAT RAM / renderer side.
    modport slave (
        output LSTART, SPVP, SPRB, SATD, DRDY,
        input  SATA, DV, DPX, DCODE, DCOL, DFX, DFY, DLY, BUSY, HITCNT, OVF
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: walks the selected SAT bank, Y-tests every
// entry against the target line, fetches X/attr/code for hits and queues one
// decoded descriptor per hit in a first-word-fall-through FIFO.
module sprite_line_scheduler #(
    parameter int SPRITES = 48,
    parameter int DEPTH   = 8,
    parameter int MAXHIT  = 24
) (
    input logic                     VCLKx8,
    input logic                     RESET_N,
    sprite_line_scheduler_if.master bus
);
    localparam int AW        = $clog2(DEPTH);
    localparam int LAST      = SPRITES - 1;
    localparam int DEPTH_I   = DEPTH;
    localparam int MAXHIT_I  = MAXHIT;
    localparam logic [5:0]  LAST_SANO = LAST[5:0];
    localparam logic [5:0]  MAX_CNT   = MAXHIT_I[5:0];
    localparam logic [AW:0] FULL_CNT  = DEPTH_I[AW:0];

    typedef enum logic [3:0] {
        ST_IDLE, ST_RD_Y, ST_CHK, ST_RD_X, ST_RD_A,
        ST_RD_C, ST_CAP, ST_PUSH, ST_DONE
    } state_t;

    typedef struct packed {
        logic [8:0] dpx;
        logic [8:0] dcode;
        logic [3:0] dcol;
        logic       dfx;
        logic       dfy;
        logic [3:0] dly;
    } desc_t;

    state_t      state, next_state;
    logic [5:0]  sano;
    logic        bank;
    logic [8:0]  spvp_q;
    logic [7:0]  x_q, attr_q, code_q;
    logic [3:0]  ht_q;
    logic [5:0]  hitcnt;
    logic        ovf;

    desc_t       fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] fifo_cnt;
    desc_t       new_desc, head;

    logic [8:0]  ht;
    logic        hit, last_sprite, fifo_full, fifo_empty, do_pop;
    logic        do_push, sano_inc, ovf_set, ht_ld, x_ld, attr_ld, code_ld;
    logic [1:0]  ofs;

    assign ht          = {1'b0, bus.SATD} - spvp_q;
    assign hit         = (bus.SATD != 8'h00) && (ht[8:4] == 5'b11111);
    assign last_sprite = (sano == LAST_SANO);
    assign fifo_empty  = (fifo_cnt == '0);
    // Full is judged on the occupancy before any same-cycle pop.
    assign fifo_full   = (fifo_cnt == FULL_CNT);
    // A line start clears the FIFO, so a pop in that cycle is discarded.
    assign do_pop      = !fifo_empty && bus.DRDY && !bus.LSTART;

    // State register.
    always_ff @(posedge VCLKx8) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!RESET_N) state <= ST_IDLE;
        else          state <= next_state;
    end

    // Next-state and per-state control strobes; LSTART restarts from any state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        next_state = state;
        do_push    = 1'b0;
        sano_inc   = 1'b0;
        ovf_set    = 1'b0;
        ht_ld      = 1'b0;
        x_ld       = 1'b0;
        attr_ld    = 1'b0;
        code_ld    = 1'b0;
        ofs        = 2'd3;
        if (bus.LSTART) begin
            next_state = ST_RD_Y;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: next_state = state;
                ST_RD_Y: next_state = ST_CHK;
                ST_CHK: begin
                    if (hit) begin
                        if (hitcnt < MAX_CNT) begin
                            ht_ld      = 1'b1;
                            next_state = ST_RD_X;
                        end else begin
                            ovf_set    = 1'b1;
                            next_state = ST_DONE;
                        end
                    end else if (last_sprite) begin
                        next_state = ST_DONE;
                    end else begin
                        sano_inc   = 1'b1;
                        next_state = ST_RD_Y;
                    end
                end
                ST_RD_X: begin
                    ofs        = 2'd2;
                    next_state = ST_RD_A;
                end
                ST_RD_A: begin
                    ofs        = 2'd1;
                    x_ld       = 1'b1;
                    next_state = ST_RD_C;
                end
                ST_RD_C: begin
                    ofs        = 2'd0;
                    attr_ld    = 1'b1;
                    next_state = ST_CAP;
                end
                ST_CAP: begin
                    ofs        = 2'd0;
                    code_ld    = 1'b1;
                    next_state = ST_PUSH;
                end
                ST_PUSH: begin
                    ofs = 2'd0;
                    if (!fifo_full) begin
                        do_push = 1'b1;
                        if (last_sprite) begin
                            next_state = ST_DONE;
                        end else begin
                            sano_inc   = 1'b1;
                            next_state = ST_RD_Y;
                        end
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Scan context and captured SAT fields.
    always_ff @(posedge VCLKx8) begin
        if (!RESET_N) begin
            sano   <= '0;
            bank   <= 1'b0;
            spvp_q <= '0;
            x_q    <= '0;
            attr_q <= '0;
            code_q <= '0;
            ht_q   <= '0;
            hitcnt <= '0;
            ovf    <= 1'b0;
        end else if (bus.LSTART) begin
            sano   <= '0;
            bank   <= bus.SPRB;
            spvp_q <= bus.SPVP;
            hitcnt <= '0;
            ovf    <= 1'b0;
        end else begin
            if (sano_inc) sano   <= sano + 6'd1;
            if (ht_ld)    ht_q   <= ht[3:0];
            if (x_ld)     x_q    <= bus.SATD;
            if (attr_ld)  attr_q <= bus.SATD;
            if (code_ld)  code_q <= bus.SATD;
            if (do_push)  hitcnt <= hitcnt + 6'd1;
            if (ovf_set)  ovf    <= 1'b1;
        end
    end

    // Descriptor decode from the captured entry.
    always_comb begin
        new_desc.dpx   = {1'b0, x_q} - {attr_q[7], 8'h00};
        new_desc.dcode = {attr_q[6], code_q};
        new_desc.dcol  = attr_q[3:0];
        new_desc.dfx   = attr_q[4];
        new_desc.dfy   = attr_q[5];
        new_desc.dly   = ht_q ^ {4{~attr_q[5]}};
    end

    // Descriptor FIFO storage and pointers.
    always_ff @(posedge VCLKx8) begin
        if (!RESET_N) begin
            // NOTE: the storage is reset on purpose: the head drives the
            // descriptor outputs directly and they must read zero after reset.
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (bus.LSTART) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= new_desc;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign bus.DV     = !fifo_empty;
    assign bus.DPX    = head.dpx;
    assign bus.DCODE  = head.dcode;
    assign bus.DCOL   = head.dcol;
    assign bus.DFX    = head.dfx;
    assign bus.DFY    = head.dfy;
    assign bus.DLY    = head.dly;
    assign bus.SATA   = (state == ST_IDLE || state == ST_DONE) ? 12'h000
                                                               : {3'b000, bank, sano, ofs};
    assign bus.BUSY   = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.HITCNT = hitcnt;
    assign bus.OVF    = ovf;
endmodule
